// File: rtl/seg7_capture.sv
// Receive side of the multiplexed seven-segment display path: waits for each
// digit's pattern to be stable, decodes it back to hex and flags frames/bad glyphs.
module seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                iSEG,
    input  logic [NUM_DIGITS-1:0]     iSEL,
    output logic [4*NUM_DIGITS-1:0]   oDIGITS,
    output logic [NUM_DIGITS-1:0]     oVALID,
    output logic                      oBAD,
    output logic                      oFRAME
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS+6:0]   samp_q;
    logic [7:0]              cnt_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic [NUM_DIGITS-1:0]   seen_q;
    logic                    bad_q;
    logic                    frame_q;

    logic [NUM_DIGITS-1:0]   sel_hot;
    logic [3:0]              zero_cnt;
    logic                    sel_active;
    logic                    match;
    logic                    capture;
    logic [4:0]              glyph;
    logic                    legal;
    logic [3:0]              value;
    logic [NUM_DIGITS-1:0]   seen_next;

    // Returns {legal, value} for an active-low segment pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_glyph = {1'b1, 4'h0};
            7'h79:   decode_glyph = {1'b1, 4'h1};
            7'h24:   decode_glyph = {1'b1, 4'h2};
            7'h30:   decode_glyph = {1'b1, 4'h3};
            7'h19:   decode_glyph = {1'b1, 4'h4};
            7'h12:   decode_glyph = {1'b1, 4'h5};
            7'h02:   decode_glyph = {1'b1, 4'h6};
            7'h78:   decode_glyph = {1'b1, 4'h7};
            7'h00:   decode_glyph = {1'b1, 4'h8};
            7'h18:   decode_glyph = {1'b1, 4'h9};
            7'h08:   decode_glyph = {1'b1, 4'hA};
            7'h03:   decode_glyph = {1'b1, 4'hB};
            7'h46:   decode_glyph = {1'b1, 4'hC};
            7'h21:   decode_glyph = {1'b1, 4'hD};
            7'h06:   decode_glyph = {1'b1, 4'hE};
            7'h0E:   decode_glyph = {1'b1, 4'hF};
            default: decode_glyph = {1'b0, 4'h0};
        endcase
    endfunction

    always_comb begin
        sel_hot  = ~iSEL;
        zero_cnt = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_cnt = zero_cnt + {3'b000, sel_hot[i]};
        end
        sel_active = (zero_cnt == 4'd1);
        match      = ({iSEL, iSEG} == samp_q);
        // Only the edge that completes the run captures; longer holds saturate.
        capture    = sel_active && match && (cnt_q == CNT_PRE);
        glyph      = decode_glyph(iSEG);
        legal      = glyph[4];
        value      = glyph[3:0];
        seen_next  = seen_q | sel_hot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_q   <= '1;
            cnt_q    <= 8'd0;
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            bad_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            samp_q  <= {iSEL, iSEG};
            bad_q   <= 1'b0;
            frame_q <= 1'b0;

            if (!sel_active) begin
                cnt_q <= 8'd0;
            end else if (match) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end else begin
                cnt_q <= 8'd1;
            end

            if (capture) begin
                if (legal) begin
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        if (sel_hot[d]) begin
                            digits_q[4*d +: 4] <= value;
                        end
                    end
                    valid_q <= valid_q | sel_hot;
                    if (&seen_next) begin
                        frame_q <= 1'b1;
                        seen_q  <= '0;
                    end else begin
                        seen_q  <= seen_next;
                    end
                end else begin
                    bad_q   <= 1'b1;
                    valid_q <= valid_q & ~sel_hot;
                end
            end
        end
    end

    assign oDIGITS = digits_q;
    assign oVALID  = valid_q;
    assign oBAD    = bad_q;
    assign oFRAME  = frame_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus random scan traffic, checked
// every cycle against a run-length reference model of the capture rules.
module tb_seg7_capture;

    localparam int ND = 4;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    iSEG = 7'h7F;
    logic [ND-1:0] iSEL = 4'hF;
    logic [4*ND-1:0] oDIGITS;
    logic [ND-1:0] oVALID;
    logic          oBAD;
    logic          oFRAME;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
        .clk     (clk),
        .reset   (reset),
        .iSEG    (iSEG),
        .iSEL    (iSEL),
        .oDIGITS (oDIGITS),
        .oVALID  (oVALID),
        .oBAD    (oBAD),
        .oFRAME  (oFRAME)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int obs_frames = 0;
    int obs_bad = 0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int          run_len;
    logic [10:0] prev_in;
    logic [15:0] exp_digits;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_seen;
    logic        exp_bad;
    logic        exp_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] sel, input logic [6:0] seg, input logic rst);
        int  k;
        int  v;
        bit  hit;
        exp_bad   = 1'b0;
        exp_frame = 1'b0;
        if (rst) begin
            run_len    = 0;
            prev_in    = '1;
            exp_digits = '0;
            exp_valid  = '0;
            exp_seen   = '0;
            return;
        end
        if ($countones(~sel) != 1) begin
            run_len = 0;
        end else if ({sel, seg} == prev_in) begin
            if (run_len == ST - 1) begin
                k = 0;
                for (int i = 0; i < ND; i++) if (!sel[i]) k = i;
                hit = 0;
                v = 0;
                for (int g = 0; g < 16; g++) if (glyph_tab[g] == seg) begin hit = 1; v = g; end
                if (hit) begin
                    exp_digits[4*k +: 4] = 4'(v);
                    exp_valid[k] = 1'b1;
                    exp_seen[k]  = 1'b1;
                    if (exp_seen == 4'hF) begin
                        exp_frame = 1'b1;
                        exp_seen  = '0;
                    end
                end else begin
                    exp_bad = 1'b1;
                    exp_valid[k] = 1'b0;
                end
            end
            run_len = (run_len + 1 > ST) ? ST : run_len + 1;
        end else begin
            run_len = 1;
        end
        prev_in = {sel, seg};
    endtask

    task automatic step(input logic [3:0] sel, input logic [6:0] seg, input logic rst);
        @(negedge clk);
        iSEL  = sel;
        iSEG  = seg;
        reset = rst;
        @(posedge clk);
        #1;
        model_edge(sel, seg, rst);
        check("digits", 32'(oDIGITS), 32'(exp_digits));
        check("valid",  32'(oVALID),  32'(exp_valid));
        check("bad",    32'(oBAD),    32'(exp_bad));
        check("frame",  32'(oFRAME),  32'(exp_frame));
        if (oFRAME) obs_frames++;
        if (oBAD) obs_bad++;
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) step(sel, seg, 1'b0);
    endtask

    task automatic scan_1234();
        hold(4'hE, 7'h79, 6);
        hold(4'hD, 7'h24, 6);
        hold(4'hB, 7'h30, 6);
        hold(4'h7, 7'h19, 6);
    endtask

    initial begin
        int f0;
        int b0;
        logic [3:0] rsel;
        logic [6:0] rseg;
        logic [3:0] idle_tab [4] = '{4'hF, 4'hC, 4'h0, 4'h5};

        // Reset and idle bus
        step(4'hF, 7'h7F, 1'b1);
        hold(4'hF, 7'h7F, 10);
        check("idle_digits", 32'(oDIGITS), 32'h0);
        check("idle_pulses", 32'(obs_frames + obs_bad), 32'h0);

        // Single digit capture, then long hold
        hold(4'hE, 7'h30, 3);
        check("pre_capture", 32'(oVALID), 32'h0);
        step(4'hE, 7'h30, 1'b0);
        check("cap_digits", 32'(oDIGITS), 32'h0003);
        check("cap_valid",  32'(oVALID),  32'h1);
        f0 = obs_frames; b0 = obs_bad;
        hold(4'hE, 7'h30, 20);
        check("hold_no_events", 32'(obs_frames - f0 + obs_bad - b0), 32'h0);

        // Interrupted run on digit 1
        hold(4'hD, 7'h24, 3);
        hold(4'hD, 7'h19, 4);
        check("restart_val", 32'(oDIGITS[7:4]), 32'h4);

        // Illegal glyph on digit 1
        b0 = obs_bad;
        hold(4'hD, 7'h7F, 4);
        check("bad_count",  32'(obs_bad - b0), 32'h1);
        check("bad_valid1", 32'(oVALID[1]), 32'h0);
        check("bad_keep",   32'(oDIGITS[7:4]), 32'h4);

        // Full scans, one frame each
        f0 = obs_frames;
        scan_1234();
        check("scan_digits", 32'(oDIGITS), 32'h4321);
        check("scan_valid",  32'(oVALID),  32'hF);
        check("scan_frame1", 32'(obs_frames - f0), 32'h1);
        scan_1234();
        check("scan_frame2", 32'(obs_frames - f0), 32'h2);

        // Two-hot select is idle; reset aborts a run
        hold(4'hC, 7'h40, 10);
        hold(4'hB, 7'h40, 2);
        step(4'hB, 7'h40, 1'b1);
        hold(4'hB, 7'h40, 3);
        check("post_rst_digits", 32'(oDIGITS), 32'h0);
        check("post_rst_valid",  32'(oVALID),  32'h0);
        step(4'hB, 7'h40, 1'b0);
        check("post_rst_cap", 32'(oVALID), 32'h4);

        // Random traffic
        for (int r = 0; r < 400; r++) begin
            case ($urandom_range(0, 11))
                0: begin
                    step(4'hF, 7'h7F, 1'b1);
                    continue;
                end
                1: rsel = idle_tab[$urandom_range(0, 3)];
                default: rsel = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 4) == 0) rseg = 7'($urandom);
            else rseg = glyph_tab[$urandom_range(0, 15)];
            hold(rsel, rseg, $urandom_range(1, 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
